ifetch_ctrl: RTL and testbench

Multicycle instruction-fetch controller for the MIPS core, directly upstream of the main/ALU control decoder. It owns the PC, fetches one word at a time from instruction memory over a request/response handshake, and holds the instruction register that feeds `op`/`func` to the decoder. After the execute side signals completion, it computes the next PC (sequential, branch, j/jal, jr) and starts the next fetch. Exactly one instruction is in flight.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/npc_calc.sv | 21 ++
 rtl/ifetch_ctrl.sv | 89 ++++++++
 tb/tb_ifetch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-controller types, reset PC and instruction field positions.
package cpu_pkg;
    localparam int INST_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int TGT_MSB  = 25;
    localparam int IMM_MSB  = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_t;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC select, priority jr > jump > branch > sequential.
import cpu_pkg::*;

module npc_calc (
    input  logic [31:0] i_pc,
    input  logic [25:0] i_target,
    input  logic [31:0] i_jr_addr,
    input  logic        i_br_taken,
    input  logic        i_jump,
    input  logic        i_jr,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_npc
);
    assign o_pc_plus4 = i_pc + 32'd4;

    always_comb
        o_npc = i_jr       ? i_jr_addr :
                i_jump     ? {o_pc_plus4[31:28], i_target, 2'b00} :
                i_br_taken ? o_pc_plus4 + br_offset(i_target[IMM_MSB:0]) :
                             o_pc_plus4;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: multicycle fetch FSM owning PC, instruction register and retire counter.
// One instruction in flight; a misaligned PC parks the FSM in ERR until reset.
import cpu_pkg::*;

module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_imem_req,
    output logic [31:0]       o_imem_addr,
    input  logic              i_imem_rvalid,
    input  logic [INST_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [5:0]        o_op,
    output logic [5:0]        o_func,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    input  logic              i_exec_done,
    input  logic              i_br_taken,
    input  logic              i_jump,
    input  logic              i_jr,
    input  logic [31:0]       i_jr_addr,
    output logic              o_fetch_err,
    output logic [31:0]       o_retired
);
    fetch_state_t      r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_retired;
    logic [INST_W-1:0] r_inst;
    logic [31:0]       w_npc;
    logic [31:0]       w_pc_plus4;
    logic              w_misaligned;

    npc_calc u_npc (
        .i_pc       (r_pc),
        .i_target   (r_inst[TGT_MSB:0]),
        .i_jr_addr  (i_jr_addr),
        .i_br_taken (i_br_taken),
        .i_jump     (i_jump),
        .i_jr       (i_jr),
        .o_pc_plus4 (w_pc_plus4),
        .o_npc      (w_npc)
    );

    assign w_misaligned = r_pc[1:0] != 2'b00;

    // Illegal encodings and ERR both land in ERR, which only reset leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_FETCH;
                ST_FETCH: r_state <= w_misaligned ? ST_ERR : ST_WAIT;
                ST_WAIT:
                    if (i_imem_rvalid) begin
                        r_inst  <= i_imem_rdata;
                        r_state <= ST_ISSUE;
                    end
                ST_ISSUE:
                    if (i_inst_ready) r_state <= ST_EXEC;
                ST_EXEC:
                    if (i_exec_done) begin
                        r_pc      <= w_npc;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= ST_FETCH;
                    end
                default:  r_state <= ST_ERR;
            endcase
        end
    end

    assign o_imem_req   = (r_state == ST_FETCH) && !w_misaligned;
    assign o_imem_addr  = r_pc;
    assign o_inst_valid = r_state == ST_ISSUE;
    assign o_fetch_err  = r_state == ST_ERR;
    assign o_inst       = r_inst;
    assign o_op         = r_inst[OP_MSB:OP_LSB];
    assign o_func       = r_inst[FUNC_MSB:FUNC_LSB];
    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pc_plus4;
    assign o_retired    = r_retired;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized transaction bench against a per-instruction PC/retire model.
// A second instance with RESET_PC at the top of memory covers the PC wrap.
module tb_ifetch_ctrl;
    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_imem_rvalid, i_inst_ready, i_exec_done, i_br_taken, i_jump, i_jr;
    logic [31:0] i_imem_rdata, i_jr_addr;
    logic        o_imem_req, o_inst_valid, o_fetch_err;
    logic [31:0] o_imem_addr, o_inst, o_pc, o_pc_plus4, o_retired;
    logic [5:0]  o_op, o_func;
    logic        d2_imem_req, d2_inst_valid, d2_fetch_err;
    logic [31:0] d2_imem_addr, d2_inst, d2_pc, d2_pc_plus4, d2_retired;
    logic [5:0]  d2_op, d2_func;

    int          n_chk = 0;
    int          n_err = 0;
    int          req_cnt = 0;
    logic [31:0] m_pc;
    int          m_ret;

    always #5 clk = ~clk;

    always @(posedge clk) if (o_imem_req) req_cnt <= req_cnt + 1;

    ifetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
        .o_inst(o_inst), .o_op(o_op), .o_func(o_func),
        .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
        .i_exec_done(i_exec_done), .i_br_taken(i_br_taken), .i_jump(i_jump),
        .i_jr(i_jr), .i_jr_addr(i_jr_addr),
        .o_fetch_err(o_fetch_err), .o_retired(o_retired)
    );

    ifetch_ctrl #(.RESET_PC(WRAP_PC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(d2_imem_req), .o_imem_addr(d2_imem_addr),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_inst_valid(d2_inst_valid), .i_inst_ready(i_inst_ready),
        .o_inst(d2_inst), .o_op(d2_op), .o_func(d2_func),
        .o_pc(d2_pc), .o_pc_plus4(d2_pc_plus4),
        .i_exec_done(i_exec_done), .i_br_taken(i_br_taken), .i_jump(i_jump),
        .i_jr(i_jr), .i_jr_addr(i_jr_addr),
        .o_fetch_err(d2_fetch_err), .o_retired(d2_retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] w,
                                            input logic br, input logic j, input logic r,
                                            input logic [31:0] ja);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (r) return ja;
        if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br) begin
            off = $signed(w[15:0]);
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic idle_inputs();
        i_imem_rvalid = 0; i_imem_rdata = 0; i_inst_ready = 0; i_exec_done = 0;
        i_br_taken = 0; i_jump = 0; i_jr = 0; i_jr_addr = 0;
    endtask

    task automatic noise_flags();
        i_br_taken = 1'($urandom); i_jump = 1'($urandom); i_jr = 1'($urandom);
        i_jr_addr = $urandom;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_pc", o_pc, RST_PC);
        chk("rst_inst", o_inst, 0);
        chk("rst_valid", o_inst_valid, 0);
        chk("rst_req", o_imem_req, 0);
        chk("rst_err", o_fetch_err, 0);
        chk("rst_retired", o_retired, 0);
        chk("rst_pc4", o_pc_plus4, RST_PC + 32'd4);
        chk("rst_d2_pc", d2_pc, WRAP_PC);
        chk("rst_d2_pc4", d2_pc_plus4, 0);
        m_pc = RST_PC;
        m_ret = 0;
        rst_n = 1;
        @(negedge clk);
        chk("req_after_rst", o_imem_req, 1);
    endtask

    // One full instruction: request, memory latency, backpressure, execute.
    task automatic do_inst(input logic [31:0] w, input int rv_lat, input int rdy_lat, input int ex_lat,
                           input logic br, input logic j, input logic r, input logic [31:0] ja);
        int n;
        int c0;
        n = 0;
        while (!o_imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", o_imem_req, 1);
        chk("imem_addr", o_imem_addr, m_pc);
        c0 = req_cnt;
        i_imem_rvalid = 0;
        @(negedge clk);
        chk("req_one_cycle", o_imem_req, 0);
        for (int i = 0; i < rv_lat; i++) begin
            i_exec_done = 1'($urandom); i_inst_ready = 1'($urandom); noise_flags();
            @(negedge clk);
            chk("wait_no_valid", o_inst_valid, 0);
        end
        i_imem_rvalid = 1; i_imem_rdata = w; i_exec_done = 0; i_inst_ready = 0;
        @(negedge clk);
        chk("issue_valid", o_inst_valid, 1);
        chk("issue_inst", o_inst, w);
        chk("issue_op", o_op, {26'd0, w[31:26]});
        chk("issue_func", o_func, {26'd0, w[5:0]});
        chk("issue_pc", o_pc, m_pc);
        chk("issue_pc4", o_pc_plus4, m_pc + 32'd4);
        for (int i = 0; i < rdy_lat; i++) begin
            i_imem_rvalid = 1'($urandom); i_imem_rdata = $urandom;
            i_exec_done = 1; noise_flags();
            @(negedge clk);
            chk("bp_valid", o_inst_valid, 1);
            chk("bp_inst_stable", o_inst, w);
            chk("bp_pc_stable", o_pc, m_pc);
        end
        i_imem_rvalid = 0; i_inst_ready = 1; i_exec_done = 0;
        @(negedge clk);
        i_inst_ready = 0;
        chk("exec_no_valid", o_inst_valid, 0);
        for (int i = 0; i < ex_lat; i++) begin
            i_imem_rvalid = 1'($urandom); i_imem_rdata = $urandom; noise_flags();
            @(negedge clk);
            chk("exec_pc_hold", o_pc, m_pc);
        end
        i_exec_done = 1; i_br_taken = br; i_jump = j; i_jr = r; i_jr_addr = ja;
        @(negedge clk);
        idle_inputs();
        m_pc = ref_npc(m_pc, w, br, j, r, ja);
        m_ret++;
        chk("next_pc", o_pc, m_pc);
        chk("retired", o_retired, 32'(m_ret));
        chk("one_req", 32'(req_cnt - c0), 1);
        chk("next_req", o_imem_req, {31'd0, m_pc[1:0] == 2'b00});
        if (m_pc[1:0] != 2'b00) begin
            @(negedge clk);
            chk("err_flag", o_fetch_err, 1);
            for (int i = 0; i < 6; i++) begin
                i_imem_rvalid = 1'($urandom); i_inst_ready = 1'($urandom);
                i_exec_done = 1'($urandom); noise_flags();
                @(negedge clk);
                chk("err_no_req", o_imem_req, 0);
                chk("err_no_valid", o_inst_valid, 0);
                chk("err_sticky", o_fetch_err, 1);
            end
            idle_inputs();
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        apply_reset();
        // Sequential at 0x3000; the wrap instance steps from FFFF_FFFC in lockstep.
        do_inst(32'h0000_0820, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_pc", m_pc, o_imem_addr);
        chk("wrap_pc", d2_pc, 0);
        chk("wrap_addr", d2_imem_addr, 0);
        chk("wrap_no_err", d2_fetch_err, 0);
        for (int k = 0; k < 3; k++) do_inst($urandom, 0, 0, 0, 0, 0, 0, 0);
        do_inst(32'h1000_FFFF, 0, 0, 0, 1, 0, 0, 0);
        chk("beq_addr", o_imem_addr, 32'h0000_3010);

        apply_reset();
        do_inst(32'h0800_0C40, 0, 0, 0, 0, 1, 0, 0);
        chk("j_addr", o_imem_addr, 32'h0000_3100);
        do_inst(32'h0800_0C40, 1, 0, 1, 1, 1, 1, 32'h0000_4000);
        chk("jr_addr", o_imem_addr, 32'h0000_4000);

        do_inst($urandom, 5, 3, 2, 0, 0, 0, 0);
        for (int k = 0; k < 25; k++)
            do_inst($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC);

        // Reset while waiting for memory; the stale response must be dropped.
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_pc", o_pc, RST_PC);
        chk("mid_rst_req", o_imem_req, 0);
        chk("mid_rst_retired", o_retired, 0);
        chk("mid_rst_valid", o_inst_valid, 0);
        m_pc = RST_PC;
        m_ret = 0;
        @(negedge clk);
        rst_n = 1;
        i_imem_rvalid = 1; i_imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_imem_rvalid = 0;
        chk("late_rv_inst", o_inst, 0);
        chk("late_rv_valid", o_inst_valid, 0);
        chk("late_rv_req", o_imem_req, 1);
        do_inst(32'h0000_0820, 0, 0, 0, 0, 0, 0, 0);

        do_inst($urandom, 1, 1, 0, 0, 0, 1, 32'h0000_3002);
        chk("err_pc", o_pc, 32'h0000_3002);
        apply_reset();
        chk("err_cleared", o_fetch_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
